// File: rtl/fixed_point_pkg.sv
// Shared fixed-point types for the state-vector datapath, plus the
// gate sequencer FSM encoding.
package fixed_point_pkg;

  localparam int FP_FRAC_BITS = 15;
  localparam logic signed [15:0] FP_ONE  = 16'sh7FFF;
  localparam logic signed [15:0] FP_ZERO = 16'sh0000;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } gate_seq_state_t;

  function automatic complex_t cplx(input logic signed [15:0] re,
                                    input logic signed [15:0] im);
    complex_t c;
    c.re = re;
    c.im = im;
    return c;
  endfunction

endpackage

// File: rtl/gate_sequencer_pair_addr_gen.sv
// Maps pair index j and target qubit k to the two amplitude addresses:
// j with a 0 inserted at bit k, and the same address with bit k set.
module pair_addr_gen #(
  parameter int AW = 4,
  parameter int QW = 2
) (
  input  logic [AW-2:0] i_j,
  input  logic [QW-1:0] i_k,
  output logic [AW-1:0] o_addr_a,
  output logic [AW-1:0] o_addr_b
);

  localparam logic [AW-1:0] ONE = AW'(1);

  logic [AW-1:0] w_j_ext;
  logic [AW-1:0] w_bit_k;
  logic [AW-1:0] w_low_mask;

  assign w_j_ext    = {1'b0, i_j};
  assign w_bit_k    = ONE << i_k;
  assign w_low_mask = w_bit_k - ONE;

  // Bits at or above k move up by one, leaving a hole at bit k.
  assign o_addr_a = ((w_j_ext & ~w_low_mask) << 1) | (w_j_ext & w_low_mask);
  assign o_addr_b = o_addr_a | w_bit_k;

endmodule

// File: rtl/gate_sequencer.sv
// Applies one latched 2x2 unitary across every amplitude pair of the state
// RAM for a chosen target qubit, one pair per cycle, writing results in place.
module gate_sequencer
  import fixed_point_pkg::*;
#(
  parameter  int NUM_QUBITS  = 4,
  parameter  int APP_LATENCY = 4,
  parameter  int RAM_LATENCY = 1,
  localparam int AW          = NUM_QUBITS,
  localparam int QW          = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [QW-1:0]   target_qubit,
  input  complex_t        u_00_in,
  input  complex_t        u_01_in,
  input  complex_t        u_10_in,
  input  complex_t        u_11_in,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr_a,
  output logic [AW-1:0]   rd_addr_b,
  input  complex_t        rd_data_a,
  input  complex_t        rd_data_b,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr_a,
  output logic [AW-1:0]   wr_addr_b,
  output complex_t        wr_data_a,
  output complex_t        wr_data_b,
  output complex_t        app_state_in_1,
  output complex_t        app_state_in_2,
  output complex_t        app_u_00,
  output complex_t        app_u_01,
  output complex_t        app_u_10,
  output complex_t        app_u_11,
  input  complex_t        app_state_out_1,
  input  complex_t        app_state_out_2,
  output gate_seq_state_t dbg_state
);

  localparam int            D      = RAM_LATENCY + APP_LATENCY;
  localparam int            JW     = AW - 1;
  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [D-1:0]  TAIL   = D'(1) << (D - 1);
  localparam logic [QW:0]   K_LIM  = (QW + 1)'(NUM_QUBITS);

  gate_seq_state_t r_state;
  gate_seq_state_t w_next;
  logic [JW-1:0]   r_j;
  logic [QW-1:0]   r_k;
  complex_t        r_u00, r_u01, r_u10, r_u11;
  logic            r_error;
  logic [D-1:0]    r_vld;
  logic [AW-1:0]   r_dly_a [D];
  logic [AW-1:0]   r_dly_b [D];

  logic            w_k_ok;
  logic            w_accept;
  logic            w_reject;
  logic            w_rd_en;
  logic [AW-1:0]   w_addr_a;
  logic [AW-1:0]   w_addr_b;

  assign w_k_ok   = ({1'b0, target_qubit} < K_LIM);
  assign w_accept = (r_state == S_IDLE) && start && w_k_ok;
  assign w_reject = (r_state == S_IDLE) && start && !w_k_ok;

  pair_addr_gen #(.AW(AW), .QW(QW)) u_addr (
    .i_j      (r_j),
    .i_k      (r_k),
    .o_addr_a (w_addr_a),
    .o_addr_b (w_addr_b)
  );

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_rd_en = 1'b1;
        busy    = 1'b1;
        if (r_j == J_LAST) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Leave once only the tail entry can still be valid: its write is
        // this cycle, so DONE lands on the cycle right after the last write.
        if ((r_vld & ~TAIL) == '0) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_k     <= '0;
      r_u00   <= '0;
      r_u01   <= '0;
      r_u10   <= '0;
      r_u11   <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_error <= w_reject;
      if (w_accept) begin
        r_j   <= '0;
        r_k   <= target_qubit;
        r_u00 <= u_00_in;
        r_u01 <= u_01_in;
        r_u10 <= u_10_in;
        r_u11 <= u_11_in;
      end else if (r_state == S_ISSUE) begin
        r_j <= r_j + JW'(1);
      end
    end
  end

  // Write-back delay line: matches read latency plus applicator latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < D; i++) begin
        r_dly_a[i] <= '0;
        r_dly_b[i] <= '0;
      end
    end else begin
      r_vld[0]   <= w_rd_en;
      r_dly_a[0] <= rd_addr_a;
      r_dly_b[0] <= rd_addr_b;
      for (int i = 1; i < D; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_dly_a[i] <= r_dly_a[i-1];
        r_dly_b[i] <= r_dly_b[i-1];
      end
    end
  end

  assign rd_en          = w_rd_en;
  assign rd_addr_a      = w_rd_en ? w_addr_a : '0;
  assign rd_addr_b      = w_rd_en ? w_addr_b : '0;
  assign error          = r_error;

  assign wr_en          = r_vld[D-1];
  assign wr_addr_a      = r_dly_a[D-1];
  assign wr_addr_b      = r_dly_b[D-1];
  assign wr_data_a      = app_state_out_1;
  assign wr_data_b      = app_state_out_2;

  assign app_state_in_1 = rd_data_a;
  assign app_state_in_2 = rd_data_b;
  assign app_u_00       = r_u00;
  assign app_u_01       = r_u01;
  assign app_u_10       = r_u10;
  assign app_u_11       = r_u11;

  assign dbg_state      = r_state;

endmodule
